// File: rtl/bus_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_pkg : shared state encoding, defaults and helpers for Wishbone bridges
// Rev 1.0
// ----------------------------------------------------------------------------
package bus_pkg;

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_busy  = 3'd1;
  localparam logic [2:0] c_st_retry = 3'd2;
  localparam logic [2:0] c_st_drain = 3'd3;
  localparam logic [2:0] c_st_hold  = 3'd4;

  localparam int unsigned c_def_timeout = 255;
  localparam int unsigned c_def_retries = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < {32'd0, v}) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_watchdog : loadable down-counter, o_expired while the count sits at zero
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_watchdog #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_en,
  output logic          o_expired
);

  logic [CW-1:0] r_count;

  // Saturates at zero so a late enable never wraps into a fresh timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_master_bridge : CPU pipeline port to Wishbone B3 classic master
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_master_bridge
  import bus_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned SW        = DW / 8,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned STALL_IDX = 1,
  parameter int unsigned TIMEOUT   = c_def_timeout,
  parameter int unsigned RETRIES   = c_def_retries
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [AW-1:0]      cpu_addr_i,
  input  logic [SW-1:0]      cpu_sel_i,
  input  logic [DW-1:0]      cpu_data_i,
  output logic [DW-1:0]      cpu_data_o,
  output logic               stallreq,
  output logic               bus_err_o,
  input  logic [DW-1:0]      wishbone_data_i,
  input  logic               wishbone_ack_i,
  input  logic               wishbone_err_i,
  output logic [AW-1:0]      wishbone_addr_o,
  output logic [DW-1:0]      wishbone_data_o,
  output logic               wishbone_we_o,
  output logic [SW-1:0]      wishbone_sel_o,
  output logic               wishbone_stb_o,
  output logic               wishbone_cyc_o
);

  localparam int unsigned   TW          = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] c_wd_load   = TW'(TIMEOUT - 1);
  localparam logic [2:0]    c_retry_max = 3'(RETRIES);

  logic [2:0]    r_state;
  logic [2:0]    r_retry;
  logic          r_cyc;
  logic          r_we;
  logic          r_berr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rd_buf;
  logic [SW-1:0] r_sel;

  logic w_stall;
  logic w_start;
  logic w_ack;
  logic w_err;
  logic w_err_retry;
  logic w_expired;
  logic w_fatal;
  logic w_wd_load;
  logic w_wd_en;
  logic w_unused;

  assign w_stall     = stall_i[STALL_IDX];
  assign w_start     = cpu_ce_i & ~flush_i;
  assign w_ack       = wishbone_ack_i;
  assign w_err       = wishbone_err_i & ~wishbone_ack_i;
  assign w_err_retry = w_err & (r_retry < c_retry_max);
  // Terminal outcome: ERR with retries exhausted, or a silent bus at timeout.
  assign w_fatal     = ~w_ack & ((w_err & ~w_err_retry) | (~wishbone_err_i & w_expired));
  assign w_wd_load   = ((r_state == c_st_idle) & w_start) | (r_state == c_st_retry);
  assign w_wd_en     = (r_state == c_st_busy) | (r_state == c_st_drain);
  assign w_unused    = ^stall_i;

  wb_watchdog #(
    .CW (TW)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_wd_load),
    .i_load_val (c_wd_load),
    .i_en       (w_wd_en),
    .o_expired  (w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_st_idle;
      r_retry  <= '0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_berr   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_buf <= '0;
      r_sel    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_start) begin
            r_addr  <= cpu_addr_i;
            r_wdata <= cpu_data_i;
            r_we    <= cpu_we_i;
            r_sel   <= cpu_sel_i;
            r_cyc   <= 1'b1;
            r_retry <= '0;
            r_state <= c_st_busy;
          end
        end
        c_st_busy: begin
          if (flush_i) begin
            r_state <= c_st_drain;
          end else if (w_ack) begin
            r_cyc <= 1'b0;
            if (!r_we) r_rd_buf <= wishbone_data_i;
            r_state <= w_stall ? c_st_hold : c_st_idle;
          end else if (w_err_retry) begin
            r_cyc   <= 1'b0;
            r_retry <= r_retry + 3'd1;
            r_state <= c_st_retry;
          end else if (w_fatal) begin
            r_cyc    <= 1'b0;
            r_berr   <= 1'b1;
            r_rd_buf <= '0;
            r_state  <= c_st_hold;
          end
        end
        c_st_retry: begin
          r_cyc   <= 1'b1;
          r_state <= c_st_busy;
        end
        c_st_drain: begin
          // The flushed result is thrown away; only the bus handshake matters.
          if (w_ack || wishbone_err_i || w_expired) begin
            r_cyc   <= 1'b0;
            r_state <= c_st_idle;
          end
        end
        c_st_hold: begin
          if (!w_stall || flush_i) begin
            r_berr  <= 1'b0;
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_cyc   <= 1'b0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  always_comb begin
    stallreq = 1'b0;
    case (r_state)
      c_st_idle:  stallreq = w_start;
      c_st_busy:  stallreq = ~w_ack & ~w_fatal;
      c_st_retry: stallreq = 1'b1;
      default:    stallreq = 1'b0;
    endcase
  end

  assign cpu_data_o = ((r_state == c_st_busy) && w_ack) ? wishbone_data_i :
                      (r_state == c_st_hold)            ? r_rd_buf        : '0;

  assign bus_err_o       = r_berr;
  assign wishbone_addr_o = r_addr;
  assign wishbone_data_o = r_wdata;
  assign wishbone_we_o   = r_we;
  assign wishbone_sel_o  = r_sel;
  assign wishbone_stb_o  = r_cyc;
  assign wishbone_cyc_o  = r_cyc;

endmodule
`default_nettype wire
